// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder: default code geometry and the
// traceback FSM state encoding (also used by the survivor-memory writer).
package viterbi_pkg;

  localparam int unsigned M_DEF = 2;              // encoder memory (K-1)
  localparam int unsigned D_DEF = 6;              // traceback depth in columns
  localparam int unsigned S_DEF = 2 ** M_DEF;     // number of trellis states
  localparam int unsigned W_DEF = $clog2(D_DEF);  // column index width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tb_fsm_e;

endpackage

// File: rtl/viterbi_traceback.sv
// Viterbi traceback unit: on a start strobe, walks the external survivor ring
// buffer backwards for D columns from a given end state, one survivor bit per
// cycle, then emits the decoded bit belonging to the oldest column.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned D = D_DEF,
  localparam int unsigned W = $clog2(D)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_wr_ptr,
  input  logic [M-1:0] i_s_end,
  input  logic         i_force_state0,
  output logic [W-1:0] o_tb_time,
  output logic [M-1:0] o_tb_state,
  input  logic         i_tb_surv_bit,
  output logic         o_dec_bit_valid,
  output logic         o_dec_bit
);

  localparam logic [W-1:0] LAST_COL = W'(D - 1);

  tb_fsm_e      r_fsm;
  logic [W-1:0] r_count;
  logic [W-1:0] r_time;
  logic [M-1:0] r_state;
  logic         r_dec_bit;
  logic         r_dec_valid;

  logic [W-1:0] w_start_time;
  logic [W-1:0] w_prev_time;

  // Start column is the newest written one; out-of-range pointers clamp to D-1.
  always_comb begin
    w_start_time = LAST_COL;
    if (32'(i_wr_ptr) >= D) begin
      w_start_time = LAST_COL;
    end else if (i_wr_ptr == '0) begin
      w_start_time = LAST_COL;
    end else begin
      w_start_time = i_wr_ptr - 1'b1;
    end
  end

  // Step one column back in the ring buffer, wrapping from 0 to D-1.
  always_comb begin
    w_prev_time = (r_time == '0) ? LAST_COL : r_time - 1'b1;
  end

  // Traceback FSM, column pointer, predecessor-state register and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_count     <= '0;
      r_time      <= '0;
      r_state     <= '0;
      r_dec_bit   <= 1'b0;
      r_dec_valid <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          if (i_force_state0) begin
            r_time  <= w_start_time;
            r_state <= i_s_end;
            r_count <= '0;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          if (r_count == LAST_COL) begin
            // Oldest column reached: its state MSB is the decoded input bit.
            r_dec_bit   <= r_state[M-1];
            r_dec_valid <= 1'b1;
            r_fsm       <= IDLE;
          end else begin
            r_state <= {r_state[M-2:0], i_tb_surv_bit};
            r_time  <= w_prev_time;
            r_count <= r_count + 1'b1;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign o_tb_time       = r_time;
  assign o_tb_state      = r_state;
  assign o_dec_bit       = r_dec_bit;
  assign o_dec_bit_valid = r_dec_valid;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback (M=2, D=6) with a behavioural
// survivor memory answering reads combinationally.
module tb_viterbi_traceback;

  localparam int unsigned M = 2;
  localparam int unsigned D = 6;
  localparam int unsigned S = 4;
  localparam int unsigned W = 3;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] wr_ptr;
  logic [M-1:0] s_end;
  logic         force_state0;
  logic [W-1:0] tb_time;
  logic [M-1:0] tb_state;
  logic         surv_bit;
  logic         dec_valid;
  logic         dec_bit;

  // Survivor memory, bit index = column*S + state.
  logic [D*S-1:0] mem_bits;

  int n_checks;
  int n_errors;

  viterbi_traceback #(
    .M (M),
    .D (D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_wr_ptr        (wr_ptr),
    .i_s_end         (s_end),
    .i_force_state0  (force_state0),
    .o_tb_time       (tb_time),
    .o_tb_state      (tb_state),
    .i_tb_surv_bit   (surv_bit),
    .o_dec_bit_valid (dec_valid),
    .o_dec_bit       (dec_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    int idx;
    idx = int'(tb_time) * S + int'(tb_state);
    surv_bit = 1'b0;
    if (idx < D * S) surv_bit = mem_bits[idx];
  end

  typedef struct {
    string          name;
    logic [D*S-1:0] mem;
    logic [W-1:0]   wr_ptr;
    logic [M-1:0]   s_end;
    logic [5:0][W-1:0] times;
    logic [5:0][M-1:0] states;
    logic           dec;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [5:0][W-1:0] p6t(input int a, b, c, d, e, f);
    logic [5:0][W-1:0] r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d); r[4] = W'(e); r[5] = W'(f);
    return r;
  endfunction

  function automatic logic [5:0][M-1:0] p6s(input int a, b, c, d, e, f);
    logic [5:0][M-1:0] r;
    r[0] = M'(a); r[1] = M'(b); r[2] = M'(c); r[3] = M'(d); r[4] = M'(e); r[5] = M'(f);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Launch one traceback and follow it column by column to its single result.
  task automatic run_vec(input vec_t v);
    mem_bits = v.mem;
    @(negedge clk);
    wr_ptr       = v.wr_ptr;
    s_end        = v.s_end;
    force_state0 = 1'b1;
    @(posedge clk);
    #1;
    force_state0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check({v.name, " tb_time"}, int'(tb_time), int'(v.times[k]));
      check({v.name, " tb_state"}, int'(tb_state), int'(v.states[k]));
      check({v.name, " valid low"}, int'(dec_valid), 0);
    end
    @(posedge clk);
    #1;
    check({v.name, " valid pulse"}, int'(dec_valid), 1);
    check({v.name, " dec_bit"}, int'(dec_bit), int'(v.dec));
    check({v.name, " time hold"}, int'(tb_time), int'(v.times[5]));
    check({v.name, " state hold"}, int'(tb_state), int'(v.states[5]));
    @(posedge clk);
    #1;
    check({v.name, " valid cleared"}, int'(dec_valid), 0);
    check({v.name, " dec_bit hold"}, int'(dec_bit), int'(v.dec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [D*S-1:0] path_mem;
    int             pulses;
    int             pulse_at;

    n_checks = 0;
    n_errors = 0;

    // Path memory: col5/st1=1, col4/st3=0, col3/st2=1, col2/st1=1, col1/st3=0.
    path_mem = '0;
    path_mem[5*S+1] = 1'b1;
    path_mem[3*S+2] = 1'b1;
    path_mem[2*S+1] = 1'b1;

    vecs[0] = '{"ones", {(D*S){1'b1}}, 3'd3, 2'd3,
                p6t(2, 1, 0, 5, 4, 3), p6s(3, 3, 3, 3, 3, 3), 1'b1};
    vecs[1] = '{"zeros", '0, 3'd0, 2'd2,
                p6t(5, 4, 3, 2, 1, 0), p6s(2, 0, 0, 0, 0, 0), 1'b0};
    vecs[2] = '{"path", path_mem, 3'd0, 2'd1,
                p6t(5, 4, 3, 2, 1, 0), p6s(1, 3, 2, 1, 3, 2), 1'b1};
    vecs[3] = '{"ones_s0", {(D*S){1'b1}}, 3'd4, 2'd0,
                p6t(3, 2, 1, 0, 5, 4), p6s(0, 1, 3, 3, 3, 3), 1'b1};
    vecs[4] = '{"zeros_w1", '0, 3'd1, 2'd3,
                p6t(0, 5, 4, 3, 2, 1), p6s(3, 2, 0, 0, 0, 0), 1'b0};

    mem_bits     = '0;
    wr_ptr       = '0;
    s_end        = '0;
    force_state0 = 1'b0;
    rst_n        = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset valid", int'(dec_valid), 0);
    check("reset dec_bit", int'(dec_bit), 0);
    check("reset tb_time", int'(tb_time), 0);
    check("reset tb_state", int'(tb_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle no pulse", int'(dec_valid), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Strobe re-asserted mid-traceback must be ignored.
    mem_bits = path_mem;
    @(negedge clk);
    wr_ptr       = 3'd0;
    s_end        = 2'd1;
    force_state0 = 1'b1;
    @(posedge clk);
    #1;
    force_state0 = 1'b0;
    pulses   = 0;
    pulse_at = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) force_state0 = 1'b1;
      if (c == 4) force_state0 = 1'b0;
      if (dec_valid) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
        check("midrun dec_bit", int'(dec_bit), 1);
      end
    end
    check("midrun pulse count", pulses, 1);
    check("midrun pulse time", pulse_at, 6);

    // Strobe held high: back-to-back tracebacks every D+1 cycles.
    @(negedge clk);
    force_state0 = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      check("held valid", int'(dec_valid), ((c % 7) == 6) ? 1 : 0);
      if (dec_valid) begin
        pulses++;
        check("held dec_bit", int'(dec_bit), 1);
      end
    end
    force_state0 = 1'b0;
    check("held pulse count", pulses, 4);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (dec_valid) pulses++;
    end
    check("held drain pulses", pulses, 1);

    // Asynchronous reset mid-traceback: clears at once, no pulse afterwards.
    mem_bits = {(D*S){1'b1}};
    @(negedge clk);
    wr_ptr       = 3'd3;
    s_end        = 2'd3;
    force_state0 = 1'b1;
    @(posedge clk);
    #1;
    force_state0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async tb_time", int'(tb_time), 0);
    check("async tb_state", int'(tb_state), 0);
    check("async dec_bit", int'(dec_bit), 0);
    check("async valid", int'(dec_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (dec_valid) pulses++;
    end
    check("async no pulse", pulses, 0);
    check("async stays idle", int'(tb_time), 0);

    // Unit still works after the abort.
    run_vec(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
